pcileech_tlps128_multibar_controller: RTL and testbench

PCILEECH_TLPS128_MULTIBAR_CONTROLLER -- requirements
Module: pcileech_tlps128_multibar_controller

---
 rtl/pcileech_tlps128_multibar_controller.sv | 234 +++++++++++++++++++++++
 tb/tb_pcileech_tlps128_multibar_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_tlps128_multibar_controller.sv
// Multi-BAR register/RAM controller with an MSI-X table, PBA and a round-robin
// interrupt sender. Each BAR is a byte-enabled dword RAM. The MSI-X table and
// PBA windows of BAR MSIX_BIR are decoded to flops instead of RAM.
module pcileech_tlps128_multibar_controller #(
    parameter int unsigned NUM_BARS          = 2,
    parameter int unsigned BAR_ADDR_W        = 17,
    parameter int unsigned NUM_MSIX          = 4,
    parameter int unsigned MSIX_BIR          = 0,
    parameter int unsigned MSIX_TABLE_OFFSET = 'h1000,
    parameter int unsigned MSIX_PBA_OFFSET   = 'h2000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_bar,
    input  logic [BAR_ADDR_W-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_data,
    output logic                  rd_error,
    input  logic                  msix_enable,
    input  logic                  msix_function_mask,
    input  logic [NUM_MSIX-1:0]   irq_trigger,
    output logic                  msix_interrupt,
    output logic [10:0]           msix_vector,
    input  logic                  msix_interrupt_ack
);

    localparam int unsigned DEPTH     = 2 ** (BAR_ADDR_W - 2);
    localparam int unsigned BAR_W     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int unsigned VEC_W     = (NUM_MSIX > 1) ? $clog2(NUM_MSIX) : 1;
    localparam int unsigned TABLE_END = MSIX_TABLE_OFFSET + 16 * NUM_MSIX;
    localparam int unsigned PBA_END   = MSIX_PBA_OFFSET + 4 * ((NUM_MSIX + 31) / 32);

    typedef enum logic [0:0] {StIdle, StSend} irq_state_e;

    // Storage
    logic [31:0] mem [NUM_BARS][DEPTH];
    logic [31:0] addr_lo_q [NUM_MSIX];
    logic [31:0] addr_hi_q [NUM_MSIX];
    logic [31:0] data_q    [NUM_MSIX];
    logic [NUM_MSIX-1:0] mask_q;

    // Read response registers
    logic        rd_valid_q;
    logic [31:0] rd_data_q;
    logic        rd_error_q;

    // Interrupt state
    irq_state_e          state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [VEC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_MSIX-1:0] pending_q, pending_d;
    logic [NUM_MSIX-1:0] eligible;
    logic                sel_found;
    logic [VEC_W-1:0]    sel_vec;
    logic [VEC_W-1:0]    cand;

    // Request decode
    logic                  accept;
    logic [31:0]           addr_dw;
    logic                  bar_ok;
    logic                  table_hit;
    logic                  pba_hit;
    logic [BAR_W-1:0]      bar_sel;
    logic [BAR_ADDR_W-3:0] ram_idx;
    logic [31:0]           tbl_off;
    logic [VEC_W-1:0]      tbl_vec;
    logic [1:0]            tbl_word;
    logic                  ram_we;
    logic                  tbl_we;
    logic [31:0]           rd_mux;
    logic                  rd_err_mux;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign req_ready      = !rd_valid_q || rd_ready;
    assign accept         = req_valid && req_ready;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_error       = rd_error_q;
    assign msix_interrupt = (state_q == StSend);
    assign msix_vector    = 11'(vec_q);

    // Address decode: BAR range check and MSI-X table / PBA windows
    always_comb begin
        addr_dw   = 32'(req_addr) & ~32'h3;
        bar_ok    = 32'(req_bar) < NUM_BARS;
        bar_sel   = BAR_W'(req_bar);
        ram_idx   = req_addr[BAR_ADDR_W-1:2];
        table_hit = bar_ok && (32'(req_bar) == MSIX_BIR) &&
                    (addr_dw >= MSIX_TABLE_OFFSET) && (addr_dw < TABLE_END);
        pba_hit   = bar_ok && (32'(req_bar) == MSIX_BIR) &&
                    (addr_dw >= MSIX_PBA_OFFSET) && (addr_dw < PBA_END);
        tbl_off   = addr_dw - MSIX_TABLE_OFFSET;
        tbl_vec   = VEC_W'(tbl_off >> 4);
        tbl_word  = 2'(tbl_off >> 2);
        ram_we    = accept && req_write && bar_ok && !table_hit && !pba_hit;
        tbl_we    = accept && req_write && table_hit;
    end

    // Read data selection for the current request
    always_comb begin
        rd_mux     = '0;
        rd_err_mux = 1'b0;
        if (!bar_ok) begin
            rd_mux     = 32'hDEADBEEF;
            rd_err_mux = 1'b1;
        end else if (table_hit) begin
            case (tbl_word)
                2'd0:    rd_mux = addr_lo_q[tbl_vec];
                2'd1:    rd_mux = addr_hi_q[tbl_vec];
                2'd2:    rd_mux = data_q[tbl_vec];
                default: rd_mux = {31'b0, mask_q[tbl_vec]};
            endcase
        end else if (pba_hit) begin
            rd_mux = 32'(pending_q);
        end else begin
            rd_mux = mem[bar_sel][ram_idx];
        end
    end

    // BAR RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) mem[bar_sel][ram_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // Read response register, held until consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_error_q <= 1'b0;
        end else if (accept && !req_write) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_mux;
            rd_error_q <= rd_err_mux;
        end else if (rd_ready) begin
            rd_valid_q <= 1'b0;
        end
    end

    // MSI-X table registers; vectors come out of reset masked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_MSIX; v++) begin
                addr_lo_q[v] <= '0;
                addr_hi_q[v] <= '0;
                data_q[v]    <= '0;
            end
            mask_q <= '1;
        end else if (tbl_we) begin
            case (tbl_word)
                2'd0:    addr_lo_q[tbl_vec] <= be_merge(addr_lo_q[tbl_vec], req_wdata, req_be);
                2'd1:    addr_hi_q[tbl_vec] <= be_merge(addr_hi_q[tbl_vec], req_wdata, req_be);
                2'd2:    data_q[tbl_vec]    <= be_merge(data_q[tbl_vec], req_wdata, req_be);
                default: if (req_be[0]) mask_q[tbl_vec] <= req_wdata[0];
            endcase
        end
    end

    // Round-robin pick: first eligible vector at or above rr_ptr, wrapping
    always_comb begin
        eligible  = pending_q & ~mask_q;
        sel_found = 1'b0;
        sel_vec   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_MSIX; i++) begin
            cand = VEC_W'((32'(rr_ptr_q) + i) % NUM_MSIX);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_vec   = cand;
            end
        end
    end

    // Interrupt FSM next state; a trigger coinciding with ack keeps the bit pending
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        rr_ptr_d  = rr_ptr_q;
        pending_d = pending_q;
        unique case (state_q)
            StIdle: begin
                if (msix_enable && !msix_function_mask && sel_found) begin
                    state_d = StSend;
                    vec_d   = sel_vec;
                end
            end
            StSend: begin
                if (msix_interrupt_ack) begin
                    state_d          = StIdle;
                    pending_d[vec_q] = 1'b0;
                    rr_ptr_d         = (32'(vec_q) == NUM_MSIX - 1) ? '0 : vec_q + VEC_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        pending_d = pending_d | irq_trigger;
    end

    // Interrupt FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            vec_q     <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_pcileech_tlps128_multibar_controller.sv
// Scoreboard bench: stimulus pushes expected read responses and interrupt
// vectors into queues; monitors pop and compare when the DUT presents them.
module tb_pcileech_tlps128_multibar_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_bar = '0;
    logic [16:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [31:0] rd_data;
    logic        rd_error;
    logic        msix_enable = 1'b0;
    logic        msix_function_mask = 1'b0;
    logic [3:0]  irq_trigger = '0;
    logic        msix_interrupt;
    logic [10:0] msix_vector;
    logic        msix_interrupt_ack = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t rsp_q[$];
    int   irq_q[$];
    int   checks = 0;
    int   failures = 0;
    rsp_t mon_rsp;
    int   mon_vec;

    pcileech_tlps128_multibar_controller dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_bar            (req_bar),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_be             (req_be),
        .rd_valid           (rd_valid),
        .rd_ready           (rd_ready),
        .rd_data            (rd_data),
        .rd_error           (rd_error),
        .msix_enable        (msix_enable),
        .msix_function_mask (msix_function_mask),
        .irq_trigger        (irq_trigger),
        .msix_interrupt     (msix_interrupt),
        .msix_vector        (msix_vector),
        .msix_interrupt_ack (msix_interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read response monitor
    always @(negedge clk) begin
        if (reset_n && rd_valid && rd_ready) begin
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %h, want no response", rd_data);
            end else begin
                mon_rsp = rsp_q.pop_front();
                check("rd_data", rd_data, mon_rsp.data);
                check("rd_error", 32'(rd_error), 32'(mon_rsp.err));
            end
        end
    end

    // Interrupt monitor: compares the vector at each accepted interrupt
    always @(negedge clk) begin
        if (reset_n && msix_interrupt && msix_interrupt_ack) begin
            if (irq_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL irq_unexpected: got vector %0d, want none", msix_vector);
            end else begin
                mon_vec = irq_q.pop_front();
                check("irq_vector", 32'(msix_vector), 32'(mon_vec));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic issue(input logic wr, input logic [2:0] bar, input logic [16:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        int n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_bar   = bar;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic wr(input logic [2:0] bar, input logic [16:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
        issue(1'b1, bar, addr, data, be);
    endtask

    task automatic rd(input logic [2:0] bar, input logic [16:0] addr,
                      input logic [31:0] exp, input logic err);
        rsp_q.push_back('{data: exp, err: err});
        issue(1'b0, bar, addr, '0, '0);
        @(negedge clk);
        check("rd_latency", 32'(rd_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trigger(input logic [3:0] v);
        irq_trigger = v;
        @(posedge clk);
        #1;
        irq_trigger = '0;
    endtask

    task automatic ack_irq(input logic [3:0] retrig);
        int n = 0;
        @(negedge clk);
        while (!msix_interrupt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("irq_raised", 32'(msix_interrupt), 32'd1);
        @(posedge clk);
        #1;
        msix_interrupt_ack = 1'b1;
        irq_trigger = retrig;
        @(posedge clk);
        #1;
        msix_interrupt_ack = 1'b0;
        irq_trigger = '0;
        @(negedge clk);
        check("irq_gap", 32'(msix_interrupt), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_error", 32'(rd_error), 32'd0);
        check("rst_irq", 32'(msix_interrupt), 32'd0);
        check("rst_vector", 32'(msix_vector), 32'd0);
        reset_n = 1'b1;
        idle(2);
        rd(3'd0, 17'h100C, 32'h1, 1'b0);
        rd(3'd0, 17'h103C, 32'h1, 1'b0);
        rd(3'd0, 17'h1000, 32'h0, 1'b0);
        rd(3'd0, 17'h2000, 32'h0, 1'b0);

        // Byte-enabled RAM write, read on the very next cycle
        wr(3'd1, 17'h40, 32'hAABBCCDD, 4'hF);
        wr(3'd1, 17'h40, 32'h00001100, 4'h2);
        rd(3'd1, 17'h40, 32'hAABB11DD, 1'b0);
        rd(3'd1, 17'h43, 32'hAABB11DD, 1'b0);

        // MSI-X table registers
        wr(3'd0, 17'h1020, 32'h12345678, 4'b0101);
        rd(3'd0, 17'h1020, 32'h00340078, 1'b0);
        wr(3'd0, 17'h1018, 32'hCAFEF00D, 4'hF);
        rd(3'd0, 17'h1018, 32'hCAFEF00D, 1'b0);
        wr(3'd0, 17'h1034, 32'h000000FF, 4'h1);
        rd(3'd0, 17'h1034, 32'h000000FF, 1'b0);
        wr(3'd0, 17'h102C, 32'hFFFFFFFE, 4'hF);
        rd(3'd0, 17'h102C, 32'h0, 1'b0);
        wr(3'd0, 17'h102C, 32'hFFFFFFFF, 4'b1110);
        rd(3'd0, 17'h102C, 32'h0, 1'b0);
        wr(3'd0, 17'h102C, 32'hFFFFFFFF, 4'h1);
        rd(3'd0, 17'h102C, 32'h1, 1'b0);
        wr(3'd0, 17'h2000, 32'hFFFFFFFF, 4'hF);
        rd(3'd0, 17'h2000, 32'h0, 1'b0);

        // Unmapped BARs
        rd(3'd5, 17'h40, 32'hDEADBEEF, 1'b1);
        rd(3'd2, 17'h40, 32'hDEADBEEF, 1'b1);
        wr(3'd5, 17'h40, 32'h11111111, 4'hF);
        rd(3'd1, 17'h40, 32'hAABB11DD, 1'b0);

        // Backpressure: response held 3 cycles, next request taken as rd_ready rises
        wr(3'd1, 17'h44, 32'h55667788, 4'hF);
        rd_ready = 1'b0;
        rsp_q.push_back('{data: 32'hAABB11DD, err: 1'b0});
        issue(1'b0, 3'd1, 17'h40, '0, '0);
        rsp_q.push_back('{data: 32'h55667788, err: 1'b0});
        req_valid = 1'b1;
        req_addr  = 17'h44;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_rd_valid", 32'(rd_valid), 32'd1);
            check("bp_rd_data", rd_data, 32'hAABB11DD);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", 32'(rd_valid), 32'd1);
        idle(1);

        // Two vectors triggered together go out in round-robin order
        msix_enable = 1'b1;
        wr(3'd0, 17'h101C, 32'h0, 4'hF);
        wr(3'd0, 17'h103C, 32'h0, 4'hF);
        irq_q.push_back(1);
        irq_q.push_back(3);
        pulse_trigger(4'b1010);
        ack_irq(4'b0000);
        rd(3'd0, 17'h2000, 32'h8, 1'b0);
        ack_irq(4'b0000);
        rd(3'd0, 17'h2000, 32'h0, 1'b0);

        // Masked vector stays pending, fires on unmask, retrigger during ack repeats it
        pulse_trigger(4'b0001);
        idle(5);
        check("masked_no_irq", 32'(msix_interrupt), 32'd0);
        rd(3'd0, 17'h2000, 32'h1, 1'b0);
        irq_q.push_back(0);
        irq_q.push_back(0);
        wr(3'd0, 17'h100C, 32'h0, 4'h1);
        ack_irq(4'b0001);
        ack_irq(4'b0000);
        rd(3'd0, 17'h2000, 32'h0, 1'b0);

        // Ack outside SEND must not clear a pending bit
        pulse_trigger(4'b0100);
        msix_interrupt_ack = 1'b1;
        @(posedge clk);
        #1;
        msix_interrupt_ack = 1'b0;
        check("idle_ack_no_irq", 32'(msix_interrupt), 32'd0);
        rd(3'd0, 17'h2000, 32'h4, 1'b0);

        // Reset during SEND with a read response outstanding
        pulse_trigger(4'b0010);
        idle(2);
        rd_ready  = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_bar   = 3'd1;
        req_addr  = 17'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        check("pre_rst_irq", 32'(msix_interrupt), 32'd1);
        check("pre_rst_vector", 32'(msix_vector), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_async_rd_data", rd_data, 32'd0);
        check("rst_async_rd_error", 32'(rd_error), 32'd0);
        check("rst_async_irq", 32'(msix_interrupt), 32'd0);
        check("rst_async_vector", 32'(msix_vector), 32'd0);
        idle(2);
        reset_n = 1'b1;
        rd_ready = 1'b1;
        idle(3);
        check("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("post_rst_irq", 32'(msix_interrupt), 32'd0);
        rd(3'd0, 17'h101C, 32'h1, 1'b0);
        rd(3'd0, 17'h2000, 32'h0, 1'b0);
        rd(3'd1, 17'h40, 32'hAABB11DD, 1'b0);

        idle(3);
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        check("irq_queue_empty", 32'(irq_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
